// File: rtl/sram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_arb_pkg
// Description : Shared types and defaults for the SRAM port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_arb_pkg;

    localparam int unsigned c_def_num_req      = 3;
    localparam int unsigned c_def_read_latency = 2;
    localparam int unsigned c_max_num_req      = 8;
    localparam int unsigned c_tag_idx_w        = 3;

    typedef enum logic [0:0] {
        S_ARB_IDLE  = 1'b0,
        S_ARB_OWNED = 1'b1
    } arb_state_t;

    // One slot of the read-return tracker: which requester owns the data.
    typedef struct packed {
        logic                   valid;
        logic [c_tag_idx_w-1:0] index;
    } rd_tag_t;

    // Round-robin start after requester idx finishes; index 0 is outside the rotation.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned num_req);
        return (idx + 1 >= num_req) ? 1 : idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_arb_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : sram_arb_rr_picker
// Description : Combinational round-robin first-one finder. Scans upward from
//               i_rr_ptr with wrap-around, skipping masked requesters, and
//               returns a one-hot pick (or zero).
// Revision    : 1.0 - initial release
// ============================================================================
module sram_arb_rr_picker
    import sram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = c_def_num_req,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_rr_ptr,
    input  logic [NUM_REQ-1:0] i_exclude,
    output logic [NUM_REQ-1:0] o_pick
);

    logic [NUM_REQ-1:0]   w_cand;
    logic [NUM_REQ-1:0]   w_rot;
    logic [NUM_REQ-1:0]   w_rot_pick;
    logic [2*NUM_REQ-1:0] w_back;

    // Rotate so the pointer lands on bit 0, isolate the lowest set bit, rotate back.
    assign w_cand     = i_req & ~i_exclude;
    assign w_rot      = NUM_REQ'({w_cand, w_cand} >> i_rr_ptr);
    assign w_rot_pick = w_rot & (-w_rot);
    assign w_back     = {{NUM_REQ{1'b0}}, w_rot_pick} << i_rr_ptr;
    assign o_pick     = w_back[2*NUM_REQ-1:NUM_REQ] | w_back[NUM_REQ-1:0];

endmodule
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_arbiter
// Description : Shares one SRAM port between NUM_REQ requesters. Requester 0
//               has fixed priority, the rest rotate round-robin, and a bounded
//               lock lets one requester keep the port for up to MAX_LOCK
//               consecutive grants. Read data returns with fixed latency.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ      = c_def_num_req,
    parameter int unsigned ADDR_W       = 18,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned READ_LATENCY = c_def_read_latency,
    parameter int unsigned MAX_LOCK     = 64
) (
    input  logic                           Clock,
    input  logic                           Reset,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0]             lock,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ-1:0]             req_we_n,
    input  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]             gnt,
    output logic [NUM_REQ-1:0]             rvalid,
    output logic [DATA_W-1:0]              rdata,
    output logic [ADDR_W-1:0]              SRAM_address_o,
    output logic [DATA_W-1:0]              SRAM_write_data_o,
    output logic                           SRAM_we_n_o,
    input  logic [DATA_W-1:0]              SRAM_read_data_i
);

    localparam int unsigned        c_idx_w     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned        c_cnt_w     = $clog2(MAX_LOCK + 1);
    localparam logic [NUM_REQ-1:0] c_req0_mask = NUM_REQ'(1);

    arb_state_t           r_state;
    arb_state_t           w_state_nxt;
    logic [c_idx_w-1:0]   r_owner;
    logic [c_idx_w-1:0]   w_owner_nxt;
    logic [c_idx_w-1:0]   r_rr_ptr;
    logic [c_idx_w-1:0]   w_rr_nxt;
    logic [c_idx_w-1:0]   w_win;
    logic [c_cnt_w-1:0]   r_lock_cnt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;
    logic [c_cnt_w-1:0]   w_cnt_inc;
    logic [NUM_REQ-1:0]   r_excl;
    logic [NUM_REQ-1:0]   w_excl_nxt;
    logic [NUM_REQ-1:0]   w_pick;
    logic [NUM_REQ-1:0]   w_gnt;
    logic                 w_gnt_any;
    rd_tag_t              r_tags [0:READ_LATENCY];

    // Pointer after requester idx finishes; requester 0 leaves the rotation untouched.
    function automatic logic [c_idx_w-1:0] f_rr_after(input logic [c_idx_w-1:0] idx,
                                                      input logic [c_idx_w-1:0] cur);
        if (idx == '0) begin
            return cur;
        end
        return c_idx_w'(rr_next(32'(idx), NUM_REQ));
    endfunction

    // Requester 0 is never part of the round-robin scan; it is handled by priority.
    sram_arb_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_idx_w)
    ) u_picker (
        .i_req     (req),
        .i_rr_ptr  (r_rr_ptr),
        .i_exclude (r_excl | c_req0_mask),
        .o_pick    (w_pick)
    );

    // Grant selection and next-state: priority/round-robin when idle, owner-only when locked.
    always_comb begin
        w_gnt       = '0;
        w_win       = '0;
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_lock_cnt;
        w_rr_nxt    = r_rr_ptr;
        w_excl_nxt  = '0;
        w_cnt_inc   = r_lock_cnt + c_cnt_w'(1);
        case (r_state)
            S_ARB_IDLE: begin
                if (req[0] && !r_excl[0]) begin
                    w_gnt = c_req0_mask;
                end else begin
                    w_gnt = w_pick;
                end
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (w_gnt[i]) begin
                        w_win = c_idx_w'(i);
                    end
                end
                if (|w_gnt) begin
                    if (lock[w_win] && MAX_LOCK > 1) begin
                        w_state_nxt = S_ARB_OWNED;
                        w_owner_nxt = w_win;
                        w_cnt_nxt   = c_cnt_w'(1);
                    end else begin
                        // Single-cycle tenure; a lock request that already hits the bound is a forced release.
                        w_rr_nxt = f_rr_after(w_win, r_rr_ptr);
                        if (lock[w_win]) begin
                            w_excl_nxt = w_gnt;
                        end
                    end
                end
            end
            S_ARB_OWNED: begin
                w_win          = r_owner;
                w_gnt[r_owner] = req[r_owner];
                if (!req[r_owner] || !lock[r_owner] || w_cnt_inc >= c_cnt_w'(MAX_LOCK)) begin
                    w_state_nxt = S_ARB_IDLE;
                    w_cnt_nxt   = '0;
                    w_rr_nxt    = f_rr_after(r_owner, r_rr_ptr);
                    // Still requesting with lock held means the bound expired: bar the owner next cycle.
                    if (req[r_owner] && lock[r_owner]) begin
                        w_excl_nxt = w_gnt;
                    end
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt = S_ARB_IDLE;
            end
        endcase
        if (Reset) begin
            w_gnt = '0;
        end
    end

    assign gnt       = w_gnt;
    assign w_gnt_any = |w_gnt;

    // Arbitration state register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state    <= S_ARB_IDLE;
            r_owner    <= '0;
            r_rr_ptr   <= c_idx_w'(1);
            r_lock_cnt <= '0;
            r_excl     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_lock_cnt <= w_cnt_nxt;
            r_excl     <= w_excl_nxt;
        end
    end

    // Register the granted access toward the controller; idle cycles deassert write enable.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            SRAM_address_o    <= '0;
            SRAM_write_data_o <= '0;
            SRAM_we_n_o       <= 1'b1;
        end else if (w_gnt_any) begin
            SRAM_address_o    <= req_addr[w_win];
            SRAM_write_data_o <= req_wdata[w_win];
            SRAM_we_n_o       <= req_we_n[w_win];
        end else begin
            SRAM_we_n_o       <= 1'b1;
        end
    end

    // Read tag shift register: slot k describes the access granted k+1 cycles ago.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int k = 0; k <= READ_LATENCY; k++) begin
                r_tags[k] <= '0;
            end
        end else begin
            r_tags[0].valid <= w_gnt_any & req_we_n[w_win];
            r_tags[0].index <= c_tag_idx_w'(w_win);
            for (int k = 1; k <= READ_LATENCY; k++) begin
                r_tags[k] <= r_tags[k-1];
            end
        end
    end

    // Decode the oldest tag into the per-requester read-valid strobe.
    always_comb begin
        rvalid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rvalid[i] = r_tags[READ_LATENCY].valid &&
                        (r_tags[READ_LATENCY].index == c_tag_idx_w'(i));
        end
    end

    assign rdata = SRAM_read_data_i;

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_arbiter
// Description : Self-checking bench for sram_arbiter: directed scenarios with
//               literal expectations plus randomized traffic compared every
//               cycle against a behavioural arbitration model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_arbiter;

    localparam int NUM_REQ  = 3;
    localparam int ADDR_W   = 18;
    localparam int DATA_W   = 16;
    localparam int RL       = 2;
    localparam int MAX_LOCK = 64;

    logic                           Clock;
    logic                           Reset;
    logic [NUM_REQ-1:0]             req;
    logic [NUM_REQ-1:0]             lock;
    logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]             req_we_n;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]             gnt;
    logic [NUM_REQ-1:0]             rvalid;
    logic [DATA_W-1:0]              rdata;
    logic [ADDR_W-1:0]              SRAM_address_o;
    logic [DATA_W-1:0]              SRAM_write_data_o;
    logic                           SRAM_we_n_o;
    logic [DATA_W-1:0]              SRAM_read_data_i;

    int n_checks = 0;
    int n_fail   = 0;

    sram_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .READ_LATENCY (RL),
        .MAX_LOCK     (MAX_LOCK)
    ) dut (
        .Clock             (Clock),
        .Reset             (Reset),
        .req               (req),
        .lock              (lock),
        .req_addr          (req_addr),
        .req_we_n          (req_we_n),
        .req_wdata         (req_wdata),
        .gnt               (gnt),
        .rvalid            (rvalid),
        .rdata             (rdata),
        .SRAM_address_o    (SRAM_address_o),
        .SRAM_write_data_o (SRAM_write_data_o),
        .SRAM_we_n_o       (SRAM_we_n_o),
        .SRAM_read_data_i  (SRAM_read_data_i)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // SRAM stand-in: read data equals the low bits of the address, RL cycles later.
    logic [DATA_W-1:0] sram_pipe [RL];
    always @(posedge Clock) begin
        sram_pipe[0] <= SRAM_address_o[DATA_W-1:0];
        for (int k = 1; k < RL; k++) sram_pipe[k] <= sram_pipe[k-1];
    end
    assign SRAM_read_data_i = sram_pipe[RL-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge Clock);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: who may be granted, what the SRAM port holds,
    // and which reads are still owed, from the arbitration rules.
    // ------------------------------------------------------------------
    typedef struct {
        int                due;
        int                idx;
        logic [DATA_W-1:0] data;
    } rd_t;

    rd_t pend[$];

    initial begin : p_model
        int                m_owner;
        int                m_cnt;
        int                m_rr;
        int                m_excl;
        int                cyc;
        int                win;
        int                k;
        bit                rel;
        bit                forced;
        logic [ADDR_W-1:0] m_addr;
        logic [DATA_W-1:0] m_wdata;
        logic              m_we_n;
        logic [NUM_REQ-1:0] eg;
        logic [NUM_REQ-1:0] erv;
        logic [DATA_W-1:0]  erd;
        m_owner = -1; m_cnt = 0; m_rr = 1; m_excl = -1; cyc = 0;
        m_addr = '0; m_wdata = '0; m_we_n = 1'b1;
        @(posedge Clock);
        forever begin
            @(negedge Clock);
            eg = '0; erv = '0; erd = '0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                erv[pend[0].idx] = 1'b1;
                erd = pend[0].data;
                void'(pend.pop_front());
            end
            win = -1;
            if (!Reset) begin
                if (m_owner >= 0) begin
                    if (req[m_owner]) win = m_owner;
                end else if (req[0] && m_excl != 0) begin
                    win = 0;
                end else begin
                    for (int n = 0; n < NUM_REQ - 1; n++) begin
                        k = 1 + ((m_rr - 1 + n) % (NUM_REQ - 1));
                        if (win < 0 && req[k] && k != m_excl) win = k;
                    end
                end
            end
            if (win >= 0) eg[win] = 1'b1;
            chk("model_gnt", 32'(gnt), 32'(eg));
            chk("model_rvalid", 32'(rvalid), 32'(erv));
            if (erv != '0) chk("model_rdata", 32'(rdata), 32'(erd));
            chk("model_sram_addr", 32'(SRAM_address_o), 32'(m_addr));
            chk("model_sram_wdata", 32'(SRAM_write_data_o), 32'(m_wdata));
            chk("model_sram_we_n", 32'(SRAM_we_n_o), 32'(m_we_n));
            if (Reset) begin
                m_owner = -1; m_cnt = 0; m_rr = 1; m_excl = -1;
                m_addr = '0; m_wdata = '0; m_we_n = 1'b1;
                pend.delete();
            end else begin
                if (win >= 0) begin
                    m_addr  = req_addr[win];
                    m_wdata = req_wdata[win];
                    m_we_n  = req_we_n[win];
                    if (req_we_n[win]) pend.push_back('{cyc + 1 + RL, win, req_addr[win][DATA_W-1:0]});
                end else begin
                    m_we_n = 1'b1;
                end
                if (m_owner >= 0) begin
                    rel = 1'b0; forced = 1'b0;
                    if (win < 0) begin
                        rel = 1'b1;
                    end else begin
                        m_cnt++;
                        if (!lock[m_owner]) rel = 1'b1;
                        else if (m_cnt >= MAX_LOCK) begin rel = 1'b1; forced = 1'b1; end
                    end
                    m_excl = -1;
                    if (rel) begin
                        if (m_owner != 0) m_rr = (m_owner == NUM_REQ - 1) ? 1 : m_owner + 1;
                        if (forced) m_excl = m_owner;
                        m_owner = -1;
                    end
                end else begin
                    m_excl = -1;
                    if (win >= 0) begin
                        if (lock[win]) begin
                            m_owner = win;
                            m_cnt   = 1;
                        end else if (win != 0) begin
                            m_rr = (win == NUM_REQ - 1) ? 1 : win + 1;
                        end
                    end
                end
            end
            cyc++;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus with literal expectations for the directed scenarios.
    // ------------------------------------------------------------------
    logic [NUM_REQ-1:0] t3_req [8] = '{3'b100, 3'b110, 3'b110, 3'b110, 3'b110, 3'b111, 3'b110, 3'b110};
    logic [NUM_REQ-1:0] t3_exp [8] = '{3'b100, 3'b010, 3'b100, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

    initial begin : p_stim
        Reset = 1'b1; req = '1; lock = '0;
        req_addr = '0; req_we_n = '1; req_wdata = '0;

        // Reset held three cycles with everyone requesting.
        for (int c = 0; c < 3; c++) begin
            @(negedge Clock);
            chk("rst_gnt", 32'(gnt), 32'h0);
            if (c > 0) begin
                chk("rst_we_n", 32'(SRAM_we_n_o), 32'h1);
                chk("rst_rvalid", 32'(rvalid), 32'h0);
            end
            next_cycle();
        end
        Reset = 1'b0;
        @(negedge Clock);
        chk("first_gnt", 32'(gnt), 32'h1);
        next_cycle();
        req = '0;
        repeat (4) next_cycle();

        // Back-to-back reads from requester 1, data returns three cycles after each grant.
        for (int n = 0; n < 7; n++) begin
            req[1]      = (n < 4);
            req_addr[1] = ADDR_W'(32'h10 + n);
            @(negedge Clock);
            chk("t2_gnt", 32'(gnt), (n < 4) ? 32'h2 : 32'h0);
            if (n >= 3) begin
                chk("t2_rvalid", 32'(rvalid), 32'h2);
                chk("t2_rdata", 32'(rdata), 32'h10 + n - 3);
            end else begin
                chk("t2_rvalid_idle", 32'(rvalid), 32'h0);
            end
            next_cycle();
        end
        req = '0;
        next_cycle();

        // Round-robin alternation with a one-cycle priority interruption.
        for (int n = 0; n < 8; n++) begin
            req = t3_req[n];
            @(negedge Clock);
            chk("t3_rr_gnt", 32'(gnt), 32'(t3_exp[n]));
            next_cycle();
        end
        req = '0;
        next_cycle();

        // Locked write from requester 2 holds off requester 0.
        req_we_n[2]  = 1'b0;
        req_addr[2]  = 18'h23E00;
        req_wdata[2] = 16'h1234;
        for (int n = 0; n < 12; n++) begin
            req  = (n == 0) ? 3'b100 : (n < 11) ? 3'b101 : 3'b001;
            lock = (n < 10) ? 3'b100 : 3'b000;
            @(negedge Clock);
            chk("t4_lock_gnt", 32'(gnt), (n < 11) ? 32'h4 : 32'h1);
            if (n == 1) begin
                chk("t4_we_n", 32'(SRAM_we_n_o), 32'h0);
                chk("t4_addr", 32'(SRAM_address_o), 32'h23E00);
                chk("t4_wdata", 32'(SRAM_write_data_o), 32'h1234);
            end
            next_cycle();
        end
        req = '0; lock = '0; req_we_n = '1;
        next_cycle();

        // Forced release after MAX_LOCK grants to a locked requester 1.
        for (int n = 0; n < MAX_LOCK + 2; n++) begin
            req  = 3'b110;
            lock = 3'b010;
            @(negedge Clock);
            if (n < MAX_LOCK)       chk("t5_held_gnt", 32'(gnt), 32'h2);
            else if (n == MAX_LOCK) chk("t5_release_gnt", 32'(gnt), 32'h4);
            else                    chk("t5_regain_gnt", 32'(gnt), 32'h2);
            next_cycle();
        end
        req = '0; lock = '0;
        repeat (4) next_cycle();

        // Reset one cycle after two reads: neither read may return.
        for (int n = 0; n < 7; n++) begin
            Reset       = (n == 2);
            req         = (n < 2) ? 3'b010 : 3'b000;
            req_addr[1] = ADDR_W'(32'h100 + n);
            @(negedge Clock);
            if (n < 2)  chk("t6_gnt", 32'(gnt), 32'h2);
            if (n >= 3) chk("t6_rvalid", 32'(rvalid), 32'h0);
            if (n == 3) chk("t6_we_n", 32'(SRAM_we_n_o), 32'h1);
            next_cycle();
        end
        Reset = 1'b0;

        // Randomized traffic, alternating short bursts with long persistent locks.
        for (int c = 0; c < 4000; c++) begin
            bit sticky;
            sticky = ((c / 250) % 2) == 1;
            Reset  = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < NUM_REQ; i++) begin
                req[i]       = sticky ? ($urandom_range(0, 49) != 0) : ($urandom_range(0, 3) != 0);
                lock[i]      = sticky ? ($urandom_range(0, 99) != 0) : ($urandom_range(0, 2) == 0);
                req_we_n[i]  = $urandom_range(0, 1) == 1;
                req_addr[i]  = ADDR_W'($urandom);
                req_wdata[i] = DATA_W'($urandom);
            end
            next_cycle();
        end
        Reset = 1'b0; req = '0; lock = '0;
        repeat (8) next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single external SRAM port between up to NUM_REQ requesters, for example the UART loader, the decode milestone units and the VGA reader, so each unit needs no private SRAM mux.
- Sits between the requesters and the SRAM controller in the project top level. It registers the selected address, write data and write-enable toward the controller.
- It returns read data to the owning requester with a fixed latency.
- Requester 0 has fixed highest priority; the remaining requesters are served round-robin; a bounded lock lets a pipelined unit keep ownership across consecutive accesses.

Parameters:
- NUM_REQ, 3, number of requesters (2..8); index 0 is highest priority.
- ADDR_W, 18, SRAM word address width.
- DATA_W, 16, SRAM data width.
- READ_LATENCY, 2, cycles from SRAM_address_o valid to SRAM_read_data_i valid.
- MAX_LOCK, 64, maximum consecutive granted cycles while lock is held.

Ports:
- Clock  in  1  system clock (50 MHz).
- Reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester access request this cycle.
- lock  in  NUM_REQ  requester asks to retain ownership after this access.
- req_addr  in  NUM_REQ x ADDR_W  per-requester word address.
- req_we_n  in  NUM_REQ  per-requester write enable, active low.
- req_wdata  in  NUM_REQ x DATA_W  per-requester write data.
- gnt  out  NUM_REQ  one-hot or zero; the access offered this cycle is accepted.
- rvalid  out  NUM_REQ  one-hot or zero; rdata belongs to this requester.
- rdata  out  DATA_W  read data, shared by all requesters.
- SRAM_address_o  out  ADDR_W  registered address to the SRAM controller.
- SRAM_write_data_o  out  DATA_W  registered write data.
- SRAM_we_n_o  out  1  registered write enable, active low.
- SRAM_read_data_i  in  DATA_W  read data from the SRAM controller.

Behaviour:
- Clock and reset: one clock, Clock. Reset is synchronous and active-high.
- Reset values (taken at the first edge with Reset=1):
  - state = S_ARB_IDLE; owner = 0; rr_ptr = 1; lock_cnt = 0.
  - SRAM_address_o = 0; SRAM_write_data_o = 0; SRAM_we_n_o = 1.
  - Tag pipeline cleared, so rvalid = 0.
  - gnt = 0 while Reset=1.
- gnt is combinational from the state registers and req. It is at most one-hot and never asserts for a requester whose req=0.
- Accepted access: if gnt[i]=1 in cycle t, the next edge registers req_addr[i], req_wdata[i] and req_we_n[i] onto the SRAM outputs.
- No access: in any cycle with no grant, SRAM_we_n_o is 1 at the next edge. Address and write data hold their previous values.
- Read return:
  - A read granted in cycle t asserts rvalid[i] in cycle t+1+READ_LATENCY.
  - In that cycle, rdata = SRAM_read_data_i (combinational pass-through).
  - Tracking uses a shift register of {valid, index} of depth 1+READ_LATENCY.
  - A granted write produces no rvalid.
  - Back-to-back reads give one rvalid per cycle, in order.
- State S_ARB_IDLE:
  - Winner is requester 0 if req[0]=1; otherwise the first req[k]=1 scanning k = rr_ptr, rr_ptr+1, ..., NUM_REQ-1, 1, ..., rr_ptr-1.
  - Grant the winner this cycle.
  - If lock[winner]=1, go to S_ARB_OWNED with owner = winner and lock_cnt = 1.
- State S_ARB_OWNED:
  - gnt[owner] = req[owner]. No other requester is granted, including requester 0 (no preemption).
  - lock_cnt increments on each cycle in which gnt[owner]=1.
  - Exit to S_ARB_IDLE when lock[owner]=0 in a granted cycle, when req[owner]=0, or when lock_cnt reaches MAX_LOCK.
  - Forced release at MAX_LOCK: the following cycle is arbitrated in S_ARB_IDLE with the owner excluded. The owner cannot regain the grant for at least one cycle.
- Round-robin pointer update: whenever a non-zero requester i finishes ownership (a single-cycle grant or an exit from S_ARB_OWNED), rr_ptr = i+1, wrapping from NUM_REQ to 1. A grant to requester 0 does not change rr_ptr.
- Simultaneous requests: requester 0 wins in S_ARB_IDLE; otherwise the round-robin order applies.
- Reset mid-transfer: in-flight reads are dropped; their rvalid is never asserted.

Decomposition:
- Package sram_arb_pkg holds:
  - typedef enum arb_state_t {S_ARB_IDLE, S_ARB_OWNED};
  - typedef struct rd_tag_t {valid, index};
  - localparams for the default NUM_REQ and READ_LATENCY.
- Sub-module sram_arb_rr_picker: a combinational round-robin first-one finder with inputs req, rr_ptr and an exclude mask, and a one-hot output.

Test Plan:
1. Reset check: Reset=1 for 3 cycles with all req=1 -> gnt=0, SRAM_we_n_o=1, rvalid=0. After release, the first grant goes to requester 0.
2. Read latency and ordering: req[1] reads addr 0x00010..0x00013 back-to-back with SRAM model data = address -> rvalid[1] at t+3..t+6 with rdata 0x0010..0x0013 in order.
3. Round-robin fairness: req[1]=req[2]=1 continuously with no lock -> gnt alternates 1,2,1,2. Asserting req[0] for 1 cycle -> gnt[0] in that cycle, after which the alternation resumes where it left off.
4. Lock without preemption: requester 2 writes 0x1234 to addr 0x23E00 with lock=1 for 10 cycles while req[0]=1 -> gnt[0] stays low for 10 cycles and rises on the cycle after lock drops. The write appears with SRAM_we_n_o=0.
5. Forced release: lock[1] held with req[1] continuous and req[2]=1 -> after 64 grants, gnt[2] is asserted in the next cycle and gnt[1] is low in that cycle.
6. Reset during reads: Reset asserted 1 cycle after 2 reads are granted -> no rvalid is asserted for either read, and SRAM_we_n_o=1.
